// File: rtl/ball_engine_pkg.sv
// Geometry constants, coordinate type and FSM encodings shared by the ball engine files.
package ball_engine_pkg;

    typedef logic signed [11:0] coord_t;

    localparam coord_t BALL_SIZE = 12'sd7;
    localparam coord_t SPEED     = 12'sd2;
    localparam coord_t PADDLE_Y  = 12'sd440;
    localparam coord_t PADDLE_H  = 12'sd10;
    localparam coord_t PADDLE_W  = 12'sd100;
    localparam coord_t BLK_SPC_X = 12'sd40;
    localparam coord_t BLK_W     = 12'sd80;
    localparam coord_t BLK_H     = 12'sd30;
    localparam coord_t ROW0_Y    = 12'sd40;
    localparam coord_t ROW1_Y    = 12'sd90;
    localparam coord_t START_X   = 12'sd316;
    localparam coord_t START_Y   = 12'sd300;
    localparam coord_t X_LIMIT   = 12'sd639;
    localparam coord_t Y_LIMIT   = 12'sd479;

    localparam logic [9:0] TICK_H = 10'd640;
    localparam logic [9:0] TICK_V = 10'd480;

    localparam int unsigned NUM_BLOCKS = 10;
    localparam logic [1:0]  HITS_DEAD  = 2'b11;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StMove  = 3'd1;
    localparam logic [2:0] StScan  = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StWait  = 3'd4;
    localparam logic [2:0] StOver  = 3'd5;

    // Blocks 0..4 form the top row, 5..9 the second row, same columns.
    function automatic coord_t block_x(input logic [3:0] idx);
        logic [3:0] col;
        col = (idx >= 4'd5) ? idx - 4'd5 : idx;
        return BLK_SPC_X + (BLK_SPC_X + BLK_W) * coord_t'({8'd0, col});
    endfunction

    function automatic coord_t block_y(input logic [3:0] idx);
        return (idx >= 4'd5) ? ROW1_Y : ROW0_Y;
    endfunction

endpackage

// File: rtl/ball_engine_box_overlap.sv
// Combinational inclusive axis-aligned box overlap test (box a against box b).
module ball_engine_box_overlap
    import ball_engine_pkg::*;
(
    input  coord_t a_x0,
    input  coord_t a_x1,
    input  coord_t a_y0,
    input  coord_t a_y1,
    input  coord_t b_x0,
    input  coord_t b_x1,
    input  coord_t b_y0,
    input  coord_t b_y1,
    output logic   hit
);

    assign hit = (a_x1 >= b_x0) && (a_x0 <= b_x1) && (a_y1 >= b_y0) && (a_y0 <= b_y1);

endmodule

// File: rtl/ball_engine.sv
// Per-frame ball motion, wall/paddle/block bounces, block-damage writes, lives and game end.
module ball_engine
    import ball_engine_pkg::*;
(
    input  logic       CLK_25MH,
    input  logic       reset,
    input  logic [9:0] hor_count,
    input  logic [9:0] ver_count,
    input  logic [9:0] paddle_pos,
    input  logic       launch,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       active_write_enable,
    output logic [5:0] active_position,
    output logic [1:0] active_data,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       cleared
);

    logic [2:0] state_q;
    coord_t     x_q, y_q, dx_q, dy_q;
    logic [1:0] lives_q;
    logic [1:0] hits_q [NUM_BLOCKS];
    logic [3:0] idx_q;
    logic [5:0] pos_q;
    logic [1:0] data_q;

    logic   frame_tick, paddle_hit, block_hit, mv_lost, all_dead;
    coord_t nx, ny, pad_x, blk_x, blk_y;
    coord_t mv_x, mv_y, mv_dx, mv_dy;

    assign frame_tick = (hor_count == TICK_H) && (ver_count == TICK_V);
    assign nx    = x_q + dx_q;
    assign ny    = y_q + dy_q;
    assign pad_x = coord_t'({2'b00, paddle_pos});
    assign blk_x = block_x(idx_q);
    assign blk_y = block_y(idx_q);

    // Paddle contact: ball bottom row inside the paddle band, strictly within the paddle span.
    ball_engine_box_overlap u_paddle (
        .a_x0 (nx),
        .a_x1 (nx + BALL_SIZE),
        .a_y0 (ny + BALL_SIZE),
        .a_y1 (ny + BALL_SIZE),
        .b_x0 (pad_x + 12'sd1),
        .b_x1 (pad_x + PADDLE_W - 12'sd1),
        .b_y0 (PADDLE_Y),
        .b_y1 (PADDLE_Y + PADDLE_H - 12'sd1),
        .hit  (paddle_hit)
    );

    ball_engine_box_overlap u_block (
        .a_x0 (x_q),
        .a_x1 (x_q + BALL_SIZE),
        .a_y0 (y_q),
        .a_y1 (y_q + BALL_SIZE),
        .b_x0 (blk_x),
        .b_x1 (blk_x + BLK_W),
        .b_y0 (blk_y),
        .b_y1 (blk_y + BLK_H),
        .hit  (block_hit)
    );

    always_comb begin
        mv_x    = nx;
        mv_dx   = dx_q;
        mv_y    = ny;
        mv_dy   = dy_q;
        mv_lost = 1'b0;
        if (nx <= 12'sd0) begin
            mv_x  = '0;
            mv_dx = SPEED;
        end else if (nx + BALL_SIZE >= X_LIMIT) begin
            mv_x  = X_LIMIT - BALL_SIZE;
            mv_dx = -SPEED;
        end
        if (ny <= 12'sd0) begin
            mv_y  = '0;
            mv_dy = SPEED;
        end else if (dy_q > 12'sd0 && paddle_hit) begin
            mv_y  = PADDLE_Y - BALL_SIZE - 12'sd1;
            mv_dy = -SPEED;
        end else if (ny + BALL_SIZE >= Y_LIMIT) begin
            mv_lost = 1'b1;
        end
    end

    always_comb begin
        all_dead = 1'b1;
        for (int i = 0; i < int'(NUM_BLOCKS); i++) begin
            if (hits_q[i] != HITS_DEAD) all_dead = 1'b0;
        end
    end

    always_ff @(posedge CLK_25MH) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= START_X;
            y_q     <= START_Y;
            dx_q    <= SPEED;
            dy_q    <= -SPEED;
            lives_q <= 2'd3;
            idx_q   <= '0;
            pos_q   <= '0;
            data_q  <= '0;
            for (int i = 0; i < int'(NUM_BLOCKS); i++) hits_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (frame_tick && launch) begin
                        dx_q    <= SPEED;
                        dy_q    <= -SPEED;
                        state_q <= StMove;
                    end
                end
                StMove: begin
                    if (mv_lost) begin
                        lives_q <= lives_q - 2'd1;
                        x_q     <= START_X;
                        y_q     <= START_Y;
                        state_q <= (lives_q == 2'd1) ? StOver : StIdle;
                    end else begin
                        x_q     <= mv_x;
                        y_q     <= mv_y;
                        dx_q    <= mv_dx;
                        dy_q    <= mv_dy;
                        idx_q   <= '0;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    // First live block that overlaps ends the scan.
                    if (hits_q[idx_q] != HITS_DEAD && block_hit) begin
                        pos_q   <= {2'b00, idx_q};
                        data_q  <= hits_q[idx_q] + 2'd1;
                        state_q <= StWrite;
                    end else if (idx_q == 4'(NUM_BLOCKS - 1)) begin
                        state_q <= StWait;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                StWrite: begin
                    hits_q[idx_q] <= hits_q[idx_q] + 2'd1;
                    dy_q          <= -dy_q;
                    state_q       <= StWait;
                end
                StWait: begin
                    if (all_dead) state_q <= StOver;
                    else if (frame_tick) state_q <= StMove;
                end
                StOver: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ball_x              = x_q[9:0];
    assign ball_y              = y_q[9:0];
    assign active_write_enable = (state_q == StWrite);
    assign active_position     = pos_q;
    assign active_data         = data_q;
    assign lives               = lives_q;
    assign game_over           = (state_q == StOver);
    assign cleared             = all_dead;

endmodule
